// File: rtl/ahb_arb_pkg.sv
// Shared encodings for the AHB round-robin arbiter: HTRANS/HBURST codes,
// arbiter states and the burst length lookup.
package ahb_arb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'd0;
   localparam logic [1:0] HTRANS_BUSY   = 2'd1;
   localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
   localparam logic [1:0] HTRANS_SEQ    = 2'd3;

   localparam logic [2:0] HBURST_SINGLE = 3'd0;
   localparam logic [2:0] HBURST_INCR   = 3'd1;
   localparam logic [2:0] HBURST_WRAP4  = 3'd2;
   localparam logic [2:0] HBURST_INCR4  = 3'd3;
   localparam logic [2:0] HBURST_WRAP8  = 3'd4;
   localparam logic [2:0] HBURST_INCR8  = 3'd5;
   localparam logic [2:0] HBURST_WRAP16 = 3'd6;
   localparam logic [2:0] HBURST_INCR16 = 3'd7;

   typedef enum logic [1:0] {
      ST_ARB    = 2'd0,
      ST_BURST  = 2'd1,
      ST_LOCKED = 2'd2
   } arb_state_e;

   // SINGLE and undefined-length INCR count as one beat: nothing to hold for.
   function automatic logic [4:0] burst_len(input logic [2:0] hburst);
      logic [4:0] len;
      case (hburst)
         HBURST_WRAP4,  HBURST_INCR4:  len = 5'd4;
         HBURST_WRAP8,  HBURST_INCR8:  len = 5'd8;
         HBURST_WRAP16, HBURST_INCR16: len = 5'd16;
         default:                      len = 5'd1;
      endcase
      return len;
   endfunction

endpackage

// File: rtl/ahb_rr_picker.sv
// Combinational winner selection: round-robin from (ptr_i + 1), or lowest
// index when AHB_ARB_FIXED_PRIORITY_EN is defined. No request -> DEFAULT_MASTER.
module ahb_rr_picker #(
   parameter  int NUM_MASTERS    = 4,
   parameter  int DEFAULT_MASTER = 0,
   localparam int MIDX_W         = $clog2(NUM_MASTERS)
) (
   input  logic [NUM_MASTERS-1:0] req_i,
   input  logic [MIDX_W-1:0]      ptr_i,
   output logic [NUM_MASTERS-1:0] gnt_o
);

`ifdef AHB_ARB_FIXED_PRIORITY_EN
   logic unused_ptr_s;
   assign unused_ptr_s = ^ptr_i;

   // Lowest-index requester wins.
   always_comb begin
      logic found;
      logic hit;
      gnt_o = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_MASTERS; k++) begin
         hit      = ~found & req_i[k];
         gnt_o[k] = hit;
         found    = found | hit;
      end
      gnt_o[DEFAULT_MASTER] = gnt_o[DEFAULT_MASTER] | ~found;
   end
`else
   // Scan upward from the slot after the last grant, wrapping.
   always_comb begin
      logic              found;
      logic              hit;
      logic [MIDX_W-1:0] idx;
      gnt_o = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         idx        = MIDX_W'((int'(ptr_i) + k) % NUM_MASTERS);
         hit        = ~found & req_i[idx];
         gnt_o[idx] = gnt_o[idx] | hit;
         found      = found | hit;
      end
      gnt_o[DEFAULT_MASTER] = gnt_o[DEFAULT_MASTER] | ~found;
   end
`endif

endmodule

// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: registered one-hot grant, address/data-phase owner indices,
// burst and lock hold. Define AHB_ARB_FIXED_PRIORITY_EN for fixed priority.
module ahb_bus_arbiter #(
   parameter  int NUM_MASTERS    = 4,
   parameter  int DEFAULT_MASTER = 0,
   localparam int MIDX_W         = $clog2(NUM_MASTERS)
) (
   input  logic                   HCLK,
   input  logic                   HRESETn,
   input  logic [NUM_MASTERS-1:0] HBUSREQ,
   input  logic [NUM_MASTERS-1:0] HLOCK,
   input  logic [1:0]             HTRANS,
   input  logic [2:0]             HBURST,
   input  logic                   HREADY,
   output logic [NUM_MASTERS-1:0] HGRANT,
   output logic [MIDX_W-1:0]      HMASTER,
   output logic [MIDX_W-1:0]      HMASTER_D,
   output logic                   HMASTLOCK
);
   import ahb_arb_pkg::*;

   localparam logic [NUM_MASTERS-1:0] GRANT_RST =
      {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
   localparam logic [MIDX_W-1:0] MIDX_RST = MIDX_W'(DEFAULT_MASTER);

   function automatic logic [MIDX_W-1:0] onehot_idx(input logic [NUM_MASTERS-1:0] oh);
      logic [MIDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         idx = idx | (oh[i] ? MIDX_W'(i) : '0);
      end
      return idx;
   endfunction

   arb_state_e             state_q, state_d;
   logic [4:0]             cnt_q, cnt_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d, winner_s;
   logic [MIDX_W-1:0]      ptr_s, grant_idx_s;
   logic [MIDX_W-1:0]      master_q, master_d_q;
   logic                   mastlock_q;
   logic [4:0]             blen_s;
   logic                   nonseq_s, seq_s, idle_s, owner_lock_s;
   logic                   enter_lock_s, enter_burst_s, burst_end_s, lock_rel_s;

   assign grant_idx_s   = onehot_idx(grant_q);
   assign blen_s        = burst_len(HBURST);
   assign owner_lock_s  = HLOCK[master_q];
   assign nonseq_s      = HREADY & (HTRANS == HTRANS_NONSEQ);
   assign seq_s         = HREADY & (HTRANS == HTRANS_SEQ);
   assign idle_s        = HREADY & (HTRANS == HTRANS_IDLE);
   assign enter_lock_s  = nonseq_s & owner_lock_s;
   assign enter_burst_s = nonseq_s & ~owner_lock_s & (blen_s > 5'd1);
   assign burst_end_s   = nonseq_s | idle_s | (seq_s & (cnt_q == 5'd1));
   assign lock_rel_s    = HREADY & (HTRANS != HTRANS_BUSY) & ~owner_lock_s;

   ahb_rr_picker #(
      .NUM_MASTERS   (NUM_MASTERS),
      .DEFAULT_MASTER(DEFAULT_MASTER)
   ) u_picker (
      .req_i(HBUSREQ),
      .ptr_i(ptr_s),
      .gnt_o(winner_s)
   );

`ifdef AHB_ARB_FIXED_PRIORITY_EN
   assign ptr_s = MIDX_RST;
`else
   logic [MIDX_W-1:0] ptr_q, ptr_d;

   // Pointer follows the grant, but only moves when the grant really changes.
   always_comb begin
      if (grant_d != grant_q) begin
         ptr_d = onehot_idx(grant_d);
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ptr_q <= MIDX_RST;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr_s = ptr_q;
`endif

   // Grant only moves in ARB or on the edge that leaves BURST; lock release
   // passes through ARB first, which gives the extra hold cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      grant_d = grant_q;
      case (state_q)
         ST_ARB: begin
            if (enter_lock_s) begin
               state_d = ST_LOCKED;
            end else if (enter_burst_s) begin
               state_d = ST_BURST;
               cnt_d   = blen_s - 5'd1;
            end else begin
               grant_d = winner_s;
            end
         end
         ST_BURST: begin
            if (enter_lock_s) begin
               state_d = ST_LOCKED;
               cnt_d   = 5'd0;
            end else if (enter_burst_s) begin
               cnt_d   = blen_s - 5'd1;
            end else if (burst_end_s) begin
               state_d = ST_ARB;
               cnt_d   = 5'd0;
               grant_d = winner_s;
            end else if (seq_s) begin
               cnt_d   = cnt_q - 5'd1;
            end else begin
               cnt_d   = cnt_q;
            end
         end
         ST_LOCKED: begin
            if (lock_rel_s) begin
               state_d = ST_ARB;
            end else begin
               state_d = ST_LOCKED;
            end
         end
         default: begin
            state_d = ST_ARB;
            cnt_d   = 5'd0;
            grant_d = winner_s;
         end
      endcase
   end

   // Arbitration state, beat counter and grant.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q <= ST_ARB;
         cnt_q   <= 5'd0;
         grant_q <= GRANT_RST;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         grant_q <= grant_d;
      end
   end

   // Address/data-phase ownership advances only on accepted transfers.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         master_q   <= MIDX_RST;
         master_d_q <= MIDX_RST;
         mastlock_q <= 1'b0;
      end else if (HREADY) begin
         master_q   <= grant_idx_s;
         master_d_q <= master_q;
         mastlock_q <= HLOCK[grant_idx_s];
      end else begin
         master_q   <= master_q;
         master_d_q <= master_d_q;
         mastlock_q <= mastlock_q;
      end
   end

   assign HGRANT    = grant_q;
   assign HMASTER   = master_q;
   assign HMASTER_D = master_d_q;
   assign HMASTLOCK = mastlock_q;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Scoreboard bench for ahb_bus_arbiter: directed per-cycle vectors push the
// expected post-edge outputs; a monitor pops and compares after each edge/reset.
module tb_ahb_bus_arbiter;

   localparam logic [1:0] T_IDLE = 2'd0;
   localparam logic [1:0] T_BUSY = 2'd1;
   localparam logic [1:0] T_NS   = 2'd2;
   localparam logic [1:0] T_SQ   = 2'd3;

   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] m;
      logic [1:0] md;
      logic       ml;
   } exp_t;

   logic       HCLK;
   logic       HRESETn;
   logic [3:0] HBUSREQ;
   logic [3:0] HLOCK;
   logic [1:0] HTRANS;
   logic [2:0] HBURST;
   logic       HREADY;
   logic [3:0] HGRANT;
   logic [1:0] HMASTER;
   logic [1:0] HMASTER_D;
   logic       HMASTLOCK;

   exp_t exp_q[$];
   int   id_q[$];
   int   step_n = 0;
   int   checks = 0;
   int   errors = 0;

   ahb_bus_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
      .HCLK     (HCLK),
      .HRESETn  (HRESETn),
      .HBUSREQ  (HBUSREQ),
      .HLOCK    (HLOCK),
      .HTRANS   (HTRANS),
      .HBURST   (HBURST),
      .HREADY   (HREADY),
      .HGRANT   (HGRANT),
      .HMASTER  (HMASTER),
      .HMASTER_D(HMASTER_D),
      .HMASTLOCK(HMASTLOCK)
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   task automatic push(input logic [3:0] eg, input logic [1:0] em,
                       input logic [1:0] emd, input logic eml);
      exp_t e;
      e.gnt = eg;
      e.m   = em;
      e.md  = emd;
      e.ml  = eml;
      exp_q.push_back(e);
      id_q.push_back(step_n);
      step_n++;
   endtask

   // Called at a negedge: drive one cycle of inputs, expect outputs after the next posedge.
   task automatic step(input logic [3:0] req, input logic [3:0] lck, input logic [1:0] tr,
                       input logic [2:0] bu, input logic rdy, input logic [3:0] eg,
                       input logic [1:0] em, input logic [1:0] emd, input logic eml);
      HBUSREQ = req;
      HLOCK   = lck;
      HTRANS  = tr;
      HBURST  = bu;
      HREADY  = rdy;
      push(eg, em, emd, eml);
      @(negedge HCLK);
   endtask

   // Monitor: compares after every clock edge and on asynchronous reset assertion.
   initial begin
      exp_t e;
      int   id;
      forever begin
         @(posedge HCLK or negedge HRESETn);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            checks++;
            if ({HGRANT, HMASTER, HMASTER_D, HMASTLOCK} !== e) begin
               errors++;
               $display("FAIL step%0d: got gnt=%b m=%0d md=%0d lock=%b, expected gnt=%b m=%0d md=%0d lock=%b",
                        id, HGRANT, HMASTER, HMASTER_D, HMASTLOCK, e.gnt, e.m, e.md, e.ml);
            end
         end
      end
   end

   initial begin
      HRESETn = 1'b0;
      HBUSREQ = 4'b0000;
      HLOCK   = 4'b0000;
      HTRANS  = T_IDLE;
      HBURST  = 3'd0;
      HREADY  = 1'b1;
      repeat (2) @(negedge HCLK);
      push(4'b0001, 2'd0, 2'd0, 1'b0);          // reset state, checked while in reset
      @(negedge HCLK);
      HRESETn = 1'b1;

`ifdef AHB_ARB_FIXED_PRIORITY_EN
      step(4'b1010, 4'b0000, T_IDLE, 3'd0, 1'b1, 4'b0010, 2'd0, 2'd0, 1'b0);
      step(4'b1010, 4'b0000, T_NS,   3'd0, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0);
      step(4'b1010, 4'b0000, T_NS,   3'd0, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
      step(4'b1000, 4'b0000, T_IDLE, 3'd0, 1'b1, 4'b1000, 2'd1, 2'd1, 1'b0);
      step(4'b1010, 4'b0000, T_IDLE, 3'd0, 1'b1, 4'b0010, 2'd3, 2'd1, 1'b0);
      step(4'b1010, 4'b0000, T_IDLE, 3'd0, 1'b1, 4'b0010, 2'd1, 2'd3, 1'b0);
`else
      // Round robin with all four requesting, SINGLE transfers.
      step(4'b1111, 4'b0000, T_NS,   3'd0, 1'b1, 4'b0010, 2'd0, 2'd0, 1'b0);
      step(4'b1111, 4'b0000, T_NS,   3'd0, 1'b1, 4'b0100, 2'd1, 2'd0, 1'b0);
      step(4'b1111, 4'b0000, T_NS,   3'd0, 1'b1, 4'b1000, 2'd2, 2'd1, 1'b0);
      step(4'b1111, 4'b0000, T_NS,   3'd0, 1'b1, 4'b0001, 2'd3, 2'd2, 1'b0);
      step(4'b1111, 4'b0000, T_NS,   3'd0, 1'b1, 4'b0010, 2'd0, 2'd3, 1'b0);
      // M2 INCR4 with a BUSY and a wait state while M1 requests.
      step(4'b0100, 4'b0000, T_IDLE, 3'd0, 1'b1, 4'b0100, 2'd1, 2'd0, 1'b0);
      step(4'b0100, 4'b0000, T_IDLE, 3'd0, 1'b1, 4'b0100, 2'd2, 2'd1, 1'b0);
      step(4'b0110, 4'b0000, T_NS,   3'd3, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);
      step(4'b0110, 4'b0000, T_BUSY, 3'd3, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);
      step(4'b0110, 4'b0000, T_SQ,   3'd3, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);
      step(4'b0110, 4'b0000, T_SQ,   3'd3, 1'b0, 4'b0100, 2'd2, 2'd2, 1'b0);
      step(4'b0110, 4'b0000, T_SQ,   3'd3, 1'b1, 4'b0100, 2'd2, 2'd2, 1'b0);
      step(4'b0110, 4'b0000, T_SQ,   3'd3, 1'b1, 4'b0010, 2'd2, 2'd2, 1'b0);
      step(4'b0010, 4'b0000, T_IDLE, 3'd0, 1'b1, 4'b0010, 2'd1, 2'd2, 1'b0);
      // Grant moves with HREADY low; owner waits.
      step(4'b1000, 4'b0000, T_IDLE, 3'd0, 1'b0, 4'b1000, 2'd1, 2'd2, 1'b0);
      // M3 locked: three SINGLEs, then an unlocked transfer, release one cycle later.
      step(4'b1000, 4'b1000, T_IDLE, 3'd0, 1'b1, 4'b1000, 2'd3, 2'd1, 1'b1);
      step(4'b1010, 4'b1000, T_NS,   3'd0, 1'b1, 4'b1000, 2'd3, 2'd3, 1'b1);
      step(4'b1010, 4'b1000, T_NS,   3'd0, 1'b1, 4'b1000, 2'd3, 2'd3, 1'b1);
      step(4'b1010, 4'b1000, T_NS,   3'd0, 1'b1, 4'b1000, 2'd3, 2'd3, 1'b1);
      step(4'b1010, 4'b0000, T_NS,   3'd0, 1'b1, 4'b1000, 2'd3, 2'd3, 1'b0);
      step(4'b1010, 4'b0000, T_IDLE, 3'd0, 1'b1, 4'b0010, 2'd3, 2'd3, 1'b0);
      // M1 INCR8 cut short by IDLE after two SEQs.
      step(4'b0010, 4'b0000, T_IDLE, 3'd0, 1'b1, 4'b0010, 2'd1, 2'd3, 1'b0);
      step(4'b0011, 4'b0000, T_NS,   3'd5, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
      step(4'b0011, 4'b0000, T_SQ,   3'd5, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
      step(4'b0011, 4'b0000, T_SQ,   3'd5, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
      step(4'b0011, 4'b0000, T_IDLE, 3'd5, 1'b1, 4'b0001, 2'd1, 2'd1, 1'b0);
      step(4'b0011, 4'b0000, T_IDLE, 3'd0, 1'b1, 4'b0010, 2'd0, 2'd1, 1'b0);
      // M1 INCR16, reset pulsed mid-burst.
      step(4'b0010, 4'b0000, T_IDLE, 3'd0, 1'b1, 4'b0010, 2'd1, 2'd0, 1'b0);
      step(4'b0011, 4'b0000, T_NS,   3'd7, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
      step(4'b0011, 4'b0000, T_SQ,   3'd7, 1'b1, 4'b0010, 2'd1, 2'd1, 1'b0);
      push(4'b0001, 2'd0, 2'd0, 1'b0);          // right after async assertion
      push(4'b0001, 2'd0, 2'd0, 1'b0);          // clock edge while held in reset
      #2 HRESETn = 1'b0;
      @(negedge HCLK);
      HRESETn = 1'b1;
      step(4'b0010, 4'b0000, T_IDLE, 3'd0, 1'b1, 4'b0010, 2'd0, 2'd0, 1'b0);
      step(4'b0001, 4'b0000, T_IDLE, 3'd0, 1'b1, 4'b0001, 2'd1, 2'd0, 1'b0);
`endif

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge HCLK);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
